// File: rtl/read_write_arbiter.sv
// read_write_arbiter: round-robin arbiter in front of one shared stateful
// register. Each grant performs an atomic read-then-write in a single cycle
// and produces a response tagged with the granted requester's index.
module read_write_arbiter #(
  parameter int COUNT_WIDTH = 3,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2   // must equal $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             i__req_valid,
  output logic [NUM_REQ-1:0]             o__req_ready,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt,
  input  logic [NUM_REQ-1:0]             i__req_sel,
  input  logic                           i__cfg_valid,
  input  logic [COUNT_WIDTH-1:0]         i__cfg_constant,
  output logic                           o__rsp_valid,
  input  logic                           i__rsp_ready,
  output logic [ID_WIDTH-1:0]            o__rsp_id,
  output logic [COUNT_WIDTH-1:0]         o__rsp_read,
  output logic [COUNT_WIDTH-1:0]         o__state
);

  logic [COUNT_WIDTH-1:0] state_reg;
  logic [COUNT_WIDTH-1:0] const_reg;
  logic [ID_WIDTH-1:0]    ptr_reg;
  logic                   rsp_valid_reg;
  logic [ID_WIDTH-1:0]    rsp_id_reg;
  logic [COUNT_WIDTH-1:0] rsp_read_reg;

  logic                   stall;
  logic                   grant_any;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [ID_WIDTH:0]      idx_sum;
  logic [ID_WIDTH-1:0]    idx;
  logic [COUNT_WIDTH-1:0] wr_data;
  logic [ID_WIDTH-1:0]    ptr_next;

  // Unpack the flattened packet bus into one lane per requester.
  logic [COUNT_WIDTH-1:0] pkt_arr [NUM_REQ];
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pkt
      assign pkt_arr[gi] = i__req_pkt[gi*COUNT_WIDTH +: COUNT_WIDTH];
    end
  endgenerate

  // A held response blocks new grants so its id/read stay stable.
  assign stall = rsp_valid_reg && !i__rsp_ready;

  // Round-robin search: first valid requester starting at the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx_sum   = '0;
    idx       = '0;
    if (!rst && !stall) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx_sum = {1'b0, ptr_reg} + (ID_WIDTH+1)'(off);
        if (idx_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
          idx_sum = idx_sum - (ID_WIDTH+1)'(NUM_REQ);
        end
        idx = idx_sum[ID_WIDTH-1:0];
        if (!grant_any && i__req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = idx;
        end
      end
    end
  end

  // Write data and the pointer value that follows the current grant.
  always_comb begin
    wr_data  = i__req_sel[grant_id] ? pkt_arr[grant_id] : const_reg;
    ptr_next = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  end

  assign o__req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;

  // Register, constant, pointer and response pipeline; the write uses the
  // constant as it was before any same-cycle configuration load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= '0;
      const_reg     <= '0;
      ptr_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_read_reg  <= '0;
    end else begin
      if (i__cfg_valid) begin
        const_reg <= i__cfg_constant;
      end
      if (grant_any) begin
        state_reg     <= wr_data;
        rsp_read_reg  <= state_reg;
        rsp_id_reg    <= grant_id;
        rsp_valid_reg <= 1'b1;
        ptr_reg       <= ptr_next;
      end else if (rsp_valid_reg && i__rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign o__rsp_valid = rsp_valid_reg;
  assign o__rsp_id    = rsp_id_reg;
  assign o__rsp_read  = rsp_read_reg;
  assign o__state     = state_reg;

endmodule

// File: tb/tb_read_write_arbiter.sv
// tb_read_write_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of the shared register and round-robin grant.
module tb_read_write_arbiter;

  localparam int CW = 3;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*CW-1:0] req_pkt;
  logic [NR-1:0]   req_sel;
  logic            cfg_valid;
  logic [CW-1:0]   cfg_constant;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [CW-1:0]   rsp_read;
  logic [CW-1:0]   state;

  int checks = 0;
  int errors = 0;

  // Reference model
  int            m_state, m_const, m_ptr, m_rid, m_rread;
  bit            m_rv;
  logic [NR-1:0] exp_ready;
  logic [NR-1:0] obs_ready;

  read_write_arbiter #(.COUNT_WIDTH(CW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .i__req_valid    (req_valid),
    .o__req_ready    (req_ready),
    .i__req_pkt      (req_pkt),
    .i__req_sel      (req_sel),
    .i__cfg_valid    (cfg_valid),
    .i__cfg_constant (cfg_constant),
    .o__rsp_valid    (rsp_valid),
    .i__rsp_ready    (rsp_ready),
    .o__rsp_id       (rsp_id),
    .o__rsp_read     (rsp_read),
    .o__state        (state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, capture the combinational grant, clock the
  // DUT and advance the model.
  task automatic drive_cycle(input logic [NR-1:0] v, input logic [NR*CW-1:0] pkt,
                             input logic [NR-1:0] sel, input logic cv,
                             input logic [CW-1:0] cc, input logic rr, input logic r);
    int  g;
    bit  stl;
    int  old_const;
    @(negedge clk);
    rst = r; req_valid = v; req_pkt = pkt; req_sel = sel;
    cfg_valid = cv; cfg_constant = cc; rsp_ready = rr;
    #1;
    obs_ready = req_ready;
    g = -1;
    stl = m_rv && !rr;
    if (!r && !stl) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    exp_ready = (g < 0) ? '0 : (NR'(1) << g);
    @(posedge clk);
    if (r) begin
      m_state = 0; m_const = 0; m_ptr = 0; m_rv = 0; m_rid = 0; m_rread = 0;
    end else begin
      old_const = m_const;
      if (cv) m_const = int'(cc);
      if (g >= 0) begin
        m_rread = m_state;
        m_state = sel[g] ? int'(pkt[g*CW +: CW]) : old_const;
        m_rid   = g;
        m_rv    = 1;
        m_ptr   = (g + 1) % NR;
      end else if (m_rv && rr) begin
        m_rv = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive_cycle('0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    drive_cycle(4'b1111, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    drive_cycle(4'b1111, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", obs_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_read !== 3'd0) begin errors++; $display("FAIL reset_rsp_read got=%0d exp=0", rsp_read); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    $display("test_reset done");
  endtask

  task automatic test_cfg_single();
    do_reset();
    drive_cycle('0, '0, '0, 1'b1, 3'd5, 1'b1, 1'b0);
    drive_cycle(4'b0010, 12'(3'd2) << 3, '0, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", obs_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_read !== 3'd0)
      begin errors++; $display("FAIL single_rsp got=v%b id%0d rd%0d exp=v1 id1 rd0", rsp_valid, rsp_id, rsp_read); end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL single_state got=%0d exp=5", state); end
    $display("test_cfg_single: id=%0d read=%0d state=%0d", rsp_id, rsp_read, state);
  endtask

  task automatic test_round_robin();
    logic [NR*CW-1:0] pkt;
    pkt = {3'd4, 3'd3, 3'd2, 3'd1};
    do_reset();
    for (int i = 0; i < NR; i++) begin
      drive_cycle(4'b1111, pkt, 4'b1111, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (obs_ready !== (NR'(1) << i)) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, obs_ready, NR'(1) << i); end
      checks++; if (rsp_id !== IW'(i) || rsp_read !== CW'(i))
        begin errors++; $display("FAIL rr_rsp[%0d] got=id%0d rd%0d exp=id%0d rd%0d", i, rsp_id, rsp_read, i, i); end
      $display("test_round_robin: grant=%b id=%0d read=%0d", obs_ready, rsp_id, rsp_read);
    end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL rr_state got=%0d exp=4", state); end
  endtask

  task automatic test_wrap();
    logic [NR-1:0] expseq [3];
    expseq[0] = 4'b0001; expseq[1] = 4'b0100; expseq[2] = 4'b0001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b0101, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (obs_ready !== expseq[i]) begin errors++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", i, obs_ready, expseq[i]); end
      $display("test_wrap: grant=%b", obs_ready);
    end
  endtask

  task automatic test_stall();
    logic [IW-1:0] id0;
    logic [CW-1:0] rd0, st0;
    id0 = rsp_id; rd0 = rsp_read; st0 = state;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b0011, {4{3'd7}}, 4'b1111, 1'b0, '0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0000", i, obs_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_read !== rd0 || state !== st0)
        begin errors++; $display("FAIL stall_hold[%0d] got=v%b id%0d rd%0d st%0d exp=v1 id%0d rd%0d st%0d",
                                 i, rsp_valid, rsp_id, rsp_read, state, id0, rd0, st0); end
    end
    drive_cycle(4'b0011, {4{3'd7}}, 4'b1111, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL stall_resume got=%b exp=0010", obs_ready); end
    $display("test_stall: resume grant=%b state=%0d", obs_ready, state);
  endtask

  task automatic test_cfg_same_cycle();
    do_reset();
    drive_cycle('0, '0, '0, 1'b1, 3'd3, 1'b1, 1'b0);
    drive_cycle(4'b0100, {4{3'd1}}, 4'b0000, 1'b1, 3'd6, 1'b1, 1'b0);
    checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL cfgsame_ready got=%b exp=0100", obs_ready); end
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL cfgsame_state got=%0d exp=3", state); end
    drive_cycle(4'b0001, {4{3'd1}}, 4'b0000, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (state !== 3'd6 || rsp_read !== 3'd3)
      begin errors++; $display("FAIL cfgsame_next got=st%0d rd%0d exp=st6 rd3", state, rsp_read); end
    $display("test_cfg_same_cycle: state=%0d", state);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive_cycle('0, '0, '0, 1'b1, 3'd7, 1'b1, 1'b0);
    drive_cycle(4'b0100, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    drive_cycle(4'b1010, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready got=%b exp=0000", obs_ready); end
    checks++; if (rsp_valid !== 1'b0 || state !== 3'd0)
      begin errors++; $display("FAIL rstmid_clear got=v%b st%0d exp=v0 st0", rsp_valid, state); end
    drive_cycle(4'b1010, {4{3'd5}}, 4'b0000, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_grant got=%b exp=0010", obs_ready); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstmid_const got=%0d exp=0", state); end
    $display("test_reset_midflight: grant=%b state=%0d", obs_ready, state);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(NR'($urandom), (NR*CW)'($urandom), NR'($urandom),
                  ($urandom_range(0, 7) == 0), CW'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, obs_ready, exp_ready); end
      checks++; if (rsp_valid !== m_rv || rsp_id !== IW'(m_rid) || rsp_read !== CW'(m_rread) || state !== CW'(m_state))
        begin errors++; $display("FAIL rand_out[%0d] got=v%b id%0d rd%0d st%0d exp=v%b id%0d rd%0d st%0d",
                                 i, rsp_valid, rsp_id, rsp_read, state, m_rv, m_rid, m_rread, m_state); end
      $display("rand %0d: grant=%b rsp v=%b id=%0d rd=%0d state=%0d", i, obs_ready, rsp_valid, rsp_id, rsp_read, state);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_pkt = '0; req_sel = '0;
    cfg_valid = 1'b0; cfg_constant = '0; rsp_ready = 1'b1;
    m_state = 0; m_const = 0; m_ptr = 0; m_rv = 0; m_rid = 0; m_rread = 0;
    test_reset();
    test_cfg_single();
    test_round_robin();
    test_wrap();
    test_stall();
    test_cfg_same_cycle();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
